hazard_ctrl_param: RTL and testbench
====================================

Name: hazard_ctrl_param

Overview:
Parametrised hazard and forwarding controller for the 5-stage in-order RISC-V pipeline (IF/ID/EX/MEM/WB, branch resolved in ID). It generalises the load-use-only stall and EX-only forwarding. New capabilities:
- ID-stage branch-operand forwarding and stalling.
- Multi-cycle EX operations (e.g. multiply) with a latency counter.
- Variable-latency data memory freeze.
- Branch flush arbitration.
- A saturating stall performance counter.

It drives the PC hold, pipeline-register hold/bubble/flush controls and all forwarding-mux selects.

Parameters:
REG_W, 5, register-index width
MUL_LAT, 3, cycles a multi-cycle op occupies EX (>=1; 1 = no stall)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1, id_rs2  in  REG_W  source indices of instruction in ID
id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
id_is_branch  in  1  instruction in ID is a branch (comparator in ID)
branch_taken_id  in  1  ID comparator AND branch result
ex_rs1, ex_rs2, ex_rd  in  REG_W  indices of instruction in EX
ex_regwrite, ex_memread, ex_multicycle  in  1  EX control
mem_rd  in  REG_W  destination of instruction in MEM
mem_regwrite, mem_memread  in  1  MEM control
mem_ready  in  1  data memory completes access this cycle
wb_rd  in  REG_W  destination in WB
wb_regwrite  in  1  WB write enable
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
bubble_id_ex  out  1  load NOP (all control 0) into ID/EX
stall_id_ex  out  1  hold ID/EX
bubble_ex_mem  out  1  load NOP into EX/MEM
stall_ex_mem  out  1  hold EX/MEM
bubble_mem_wb  out  1  load NOP into MEM/WB
flush_if_id  out  1  clear IF/ID to NOP
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result
fwd_br_a, fwd_br_b  out  2  ID comparator operand select, same encoding
mul_busy  out  1  multi-cycle op stalling
stall_count  out  CNT_W  cycles with stall_pc=1

Behaviour:
- Register x0: never matches. Any match with index 0 is ignored for forwarding and hazards.
- EX forwarding (combinational):
  - fwd_a=10 if mem_regwrite & !mem_memread & mem_rd==ex_rs1.
  - Else 01 if wb_regwrite & wb_rd==ex_rs1.
  - Else 00.
  - fwd_b uses ex_rs2 with the same rules.
  - MEM has priority over WB.
- Branch forwarding: same rules applied to id_rs1/id_rs2, with the same MEM and WB sources, into fwd_br_a/b.
- Hazard conditions, combinational, evaluated in this priority order:
  1. MEMWAIT: mem_ready=0 & (mem_memread | mem_regwrite store/any access).
     - Assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb.
     - Multi-cycle counter frozen.
  2. MULBUSY: ex_multicycle=1 & cnt != MUL_LAT-1.
     - Assert stall_pc, stall_if_id, stall_id_ex, bubble_ex_mem, mul_busy.
  3. DATA: any one of the following, for a used ID source:
     - load-use: ex_memread & ex_rd matches.
     - branch-on-EX: id_is_branch & ex_regwrite & ex_rd matches.
     - branch-on-load-in-MEM: id_is_branch & mem_memread & mem_rd matches.
     - Response: assert stall_pc, stall_if_id, bubble_id_ex.
  4. FLUSH: branch_taken_id=1 and no higher condition active → flush_if_id=1.
     - branch_taken_id is ignored whenever the ID stage is stalled.
- Multi-cycle counter cnt (width clog2(MUL_LAT), min 1):
  - Reset to 0.
  - While ex_multicycle & !MEMWAIT: cnt increments when cnt<MUL_LAT-1, and returns to 0 on the cycle cnt==MUL_LAT-1 (stall released that cycle).
  - When ex_multicycle=0, cnt is 0.
  - The op therefore occupies EX for MUL_LAT cycles with MUL_LAT-1 stall cycles.
  - A back-to-back multi-cycle op restarts from 0.
- stall_count:
  - Increments on each clk edge where stall_pc=1.
  - Saturates at all-ones.
  - Reset 0.
- Reset:
  - While rst=1 all outputs are 0; fwd selects are 00.
  - cnt and stall_count clear on the next edge.
  - Reset mid multi-cycle op abandons it; no stall after rst falls unless ex_multicycle is still high, in which case counting restarts from 0.
- Outputs other than stall_count and mul_busy are purely combinational from inputs and cnt. mul_busy is combinational from cnt/ex_multicycle. Zero-cycle latency.

Test Plan:
- EX forwarding, x5 written by both MEM and WB: mem_rd=5 ALU, wb_rd=5, ex_rs1=5 → fwd_a=10. With mem_regwrite=0 → fwd_a=01. With ex_rs1=0 and mem_rd=0 → fwd_a=00.
- Load-use: ex_memread=1, ex_rd=7, id_rs2=7, id_use_rs2=1 → exactly 1 cycle of stall_pc=stall_if_id=bubble_id_ex=1. Next cycle (load in MEM, non-branch) no stall; fwd from WB after that.
- Branch hazard: id_is_branch, id_rs1=3, ex_regwrite ex_rd=3 → 1 stall, branch_taken_id ignored. Next cycle fwd_br_a=10. branch_taken_id=1 → flush_if_id=1 for 1 cycle.
- MUL_LAT=3, ex_multicycle held → mul_busy/stall_pc high 2 cycles, bubble_ex_mem high 2 cycles, released on 3rd. Two consecutive mul ops → 4 stall cycles total.
- mem_ready=0 for 3 cycles during a load, concurrent with a mul in EX at cnt=1 → MEMWAIT outputs for 3 cycles, cnt stays 1. Afterwards 1 more MULBUSY cycle. stall_count increases by 4.
- rst asserted at cnt=1 → all outputs 0 immediately, cnt=0 and stall_count=0 next edge. stall_count preset near max saturates at 2^CNT_W-1.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// Hazard and forwarding controller for a 5-stage in-order RISC-V pipeline
// with branches resolved in ID. Produces the PC/pipeline-register
// hold, bubble and flush controls, the EX and ID forwarding selects, a
// multi-cycle EX latency counter and a saturating stall counter.
module hazard_ctrl_param #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_branch,
    input  logic             branch_taken_id,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_multicycle,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             stall_id_ex,
    output logic             bubble_ex_mem,
    output logic             stall_ex_mem,
    output logic             bubble_mem_wb,
    output logic             flush_if_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_br_a,
    output logic [1:0]       fwd_br_b,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    // A single-cycle EX op still needs a 1-bit counter that never leaves 0.
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    // Highest-priority hazard active this cycle.
    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_MEMWAIT,
        HZ_MULBUSY,
        HZ_DATA,
        HZ_FLUSH
    } hazard_e;

    hazard_e       hazard;
    logic [CW-1:0] cnt;
    logic          memwait;
    logic          mul_wait;
    logic          rs1_hz;
    logic          rs2_hz;

    // Forwarding select for one source index. A load still in MEM has no
    // data yet, so only ALU results are taken from MEM; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] m_rd,
        input logic             m_regwrite,
        input logic             m_memread,
        input logic [REG_W-1:0] w_rd,
        input logic             w_regwrite
    );
        if (src != '0 && m_regwrite && !m_memread && m_rd == src)
            return 2'b10;
        else if (src != '0 && w_regwrite && w_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Memory access in flight that has not completed freezes the whole pipe.
    assign memwait  = !mem_ready && (mem_memread || mem_regwrite);
    assign mul_wait = ex_multicycle && (cnt != CNT_LAST);

    // A used ID source depends on a value that cannot be forwarded in time.
    assign rs1_hz = id_use_rs1 && (id_rs1 != '0) &&
                    ((ex_memread && ex_rd == id_rs1) ||
                     (id_is_branch && ex_regwrite && ex_rd == id_rs1) ||
                     (id_is_branch && mem_memread && mem_rd == id_rs1));
    assign rs2_hz = id_use_rs2 && (id_rs2 != '0) &&
                    ((ex_memread && ex_rd == id_rs2) ||
                     (id_is_branch && ex_regwrite && ex_rd == id_rs2) ||
                     (id_is_branch && mem_memread && mem_rd == id_rs2));

    assign mul_busy = !rst && mul_wait;

    // Select the winning hazard and decode it into pipeline controls and forwarding selects.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        hazard        = HZ_NONE;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        stall_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        stall_ex_mem  = 1'b0;
        bubble_mem_wb = 1'b0;
        flush_if_id   = 1'b0;
        fwd_a         = 2'b00;
        fwd_b         = 2'b00;
        fwd_br_a      = 2'b00;
        fwd_br_b      = 2'b00;

        if (rst)                    hazard = HZ_NONE;
        else if (memwait)           hazard = HZ_MEMWAIT;
        else if (mul_wait)          hazard = HZ_MULBUSY;
        else if (rs1_hz || rs2_hz)  hazard = HZ_DATA;
        else if (branch_taken_id)   hazard = HZ_FLUSH;

        case (hazard)
            HZ_MEMWAIT: begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                stall_ex_mem  = 1'b1;
                bubble_mem_wb = 1'b1;
            end
            HZ_MULBUSY: begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                bubble_ex_mem = 1'b1;
            end
            HZ_DATA: begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                bubble_id_ex  = 1'b1;
            end
            HZ_FLUSH: flush_if_id = 1'b1;
            default: ;
        endcase

        if (!rst) begin
            fwd_a    = fwd_sel(ex_rs1, mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite);
            fwd_b    = fwd_sel(ex_rs2, mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite);
            fwd_br_a = fwd_sel(id_rs1, mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite);
            fwd_br_b = fwd_sel(id_rs2, mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite);
        end
    end

    // Multi-cycle EX latency counter: frozen by a memory wait, wraps on the release cycle.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (!ex_multicycle)
            cnt <= '0;
        else if (memwait)
            cnt <= cnt;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall_pc && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed testbench for hazard_ctrl_param. A second instance with a
// 3-bit stall counter exercises saturation on the same stimulus.
module tb_hazard_ctrl_param;

    localparam int REG_W = 5;

    // Control vector order: stall_pc, stall_if_id, bubble_id_ex, stall_id_ex,
    // bubble_ex_mem, stall_ex_mem, bubble_mem_wb, flush_if_id
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_MEMW = 8'b1101_0110;
    localparam logic [7:0] C_MUL  = 8'b1101_1000;
    localparam logic [7:0] C_DATA = 8'b1110_0000;
    localparam logic [7:0] C_FLSH = 8'b0000_0001;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             id_use_rs1, id_use_rs2, id_is_branch, branch_taken_id;
    logic             ex_regwrite, ex_memread, ex_multicycle;
    logic             mem_regwrite, mem_memread, mem_ready, wb_regwrite;

    logic        stall_pc, stall_if_id, bubble_id_ex, stall_id_ex;
    logic        bubble_ex_mem, stall_ex_mem, bubble_mem_wb, flush_if_id;
    logic [1:0]  fwd_a, fwd_b, fwd_br_a, fwd_br_b;
    logic        mul_busy;
    logic [31:0] stall_count;

    logic        s_stall_pc, s_stall_if_id, s_bubble_id_ex, s_stall_id_ex;
    logic        s_bubble_ex_mem, s_stall_ex_mem, s_bubble_mem_wb, s_flush_if_id;
    logic [1:0]  s_fwd_a, s_fwd_b, s_fwd_br_a, s_fwd_br_b;
    logic        s_mul_busy;
    logic [2:0]  s_stall_count;

    logic [7:0]  ctl;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_sc;
    logic [2:0]  exp_sc_s;
    logic [31:0] base;

    assign ctl = {stall_pc, stall_if_id, bubble_id_ex, stall_id_ex,
                  bubble_ex_mem, stall_ex_mem, bubble_mem_wb, flush_if_id};

    hazard_ctrl_param #(.REG_W(REG_W), .MUL_LAT(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch), .branch_taken_id(branch_taken_id),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_multicycle(ex_multicycle),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .stall_id_ex(stall_id_ex), .bubble_ex_mem(bubble_ex_mem), .stall_ex_mem(stall_ex_mem),
        .bubble_mem_wb(bubble_mem_wb), .flush_if_id(flush_if_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_br_a(fwd_br_a), .fwd_br_b(fwd_br_b),
        .mul_busy(mul_busy), .stall_count(stall_count)
    );

    hazard_ctrl_param #(.REG_W(REG_W), .MUL_LAT(3), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch), .branch_taken_id(branch_taken_id),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_multicycle(ex_multicycle),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .stall_pc(s_stall_pc), .stall_if_id(s_stall_if_id), .bubble_id_ex(s_bubble_id_ex),
        .stall_id_ex(s_stall_id_ex), .bubble_ex_mem(s_bubble_ex_mem), .stall_ex_mem(s_stall_ex_mem),
        .bubble_mem_wb(s_bubble_mem_wb), .flush_if_id(s_flush_if_id),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_br_a(s_fwd_br_a), .fwd_br_b(s_fwd_br_b),
        .mul_busy(s_mul_busy), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quiet pipeline: no hazards, no forwarding, memory ready.
    task automatic idle();
        rst = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_is_branch = 1'b0; branch_taken_id = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_multicycle = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0; mem_ready = 1'b1;
        wb_rd = '0; wb_regwrite = 1'b0;
    endtask

    // Advance one clock and update the stall-counter reference model.
    task automatic tick(input logic stalled);
        @(posedge clk);
        if (rst) begin
            exp_sc = '0;
            exp_sc_s = '0;
        end else if (stalled) begin
            if (exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 1;
            if (exp_sc_s != 3'b111) exp_sc_s = exp_sc_s + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        ex_multicycle = 1'b1; ex_memread = 1'b1; ex_rd = 5'd2;
        id_rs1 = 5'd2; id_use_rs1 = 1'b1; branch_taken_id = 1'b1;
        mem_rd = 5'd2; mem_regwrite = 1'b1; ex_rs1 = 5'd2;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
        total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL reset_mul_busy got=%b exp=0", mul_busy); end
        total++; if ({fwd_a, fwd_br_a} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_br_a}); end
        tick(1'b0);
        tick(1'b0);
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
        total++; if (s_stall_count !== 3'd0) begin bad++; $display("FAIL reset_count_small got=%0d exp=0", s_stall_count); end
        idle();
        tick(1'b0);
    endtask

    task automatic test_ex_forwarding();
        idle();
        mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1; ex_rs1 = 5'd5;
        #1;
        total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_a_mem got=%b exp=10", fwd_a); end
        mem_regwrite = 1'b0;
        #1;
        total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_a_wb got=%b exp=01", fwd_a); end
        mem_regwrite = 1'b1; mem_memread = 1'b1;
        #1;
        total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_a_load_in_mem got=%b exp=01", fwd_a); end
        mem_memread = 1'b0; ex_rs2 = 5'd6; wb_rd = 5'd6;
        #1;
        total++; if ({fwd_a, fwd_b} !== 4'b1001) begin bad++; $display("FAIL fwd_ab_split got=%b exp=1001", {fwd_a, fwd_b}); end
        ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs2 = 5'd0;
        #1;
        total++; if ({fwd_a, fwd_b} !== 4'b0000) begin bad++; $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a, fwd_b}); end
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL fwd_ctl got=%b exp=%b", ctl, C_NONE); end
        tick(1'b0);
    endtask

    task automatic test_load_use();
        idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        total++; if (ctl !== C_DATA) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", ctl, C_DATA); end
        tick(1'b1);
        idle();
        mem_rd = 5'd7; mem_memread = 1'b1; mem_regwrite = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL load_use_release got=%b exp=%b", ctl, C_NONE); end
        id_is_branch = 1'b1;
        #1;
        total++; if (ctl !== C_DATA) begin bad++; $display("FAIL branch_on_load_mem got=%b exp=%b", ctl, C_DATA); end
        id_is_branch = 1'b0;
        tick(1'b0);
        idle();
        ex_rs2 = 5'd7; wb_rd = 5'd7; wb_regwrite = 1'b1;
        #1;
        total++; if (fwd_b !== 2'b01) begin bad++; $display("FAIL load_use_fwd_wb got=%b exp=01", fwd_b); end
        tick(1'b0);
        idle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, C_NONE); end
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL load_use_unused got=%b exp=%b", ctl, C_NONE); end
        tick(1'b0);
    endtask

    task automatic test_branch();
        idle();
        id_is_branch = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        ex_regwrite = 1'b1; ex_rd = 5'd3; branch_taken_id = 1'b1;
        #1;
        total++; if (ctl !== C_DATA) begin bad++; $display("FAIL branch_ex_stall got=%b exp=%b", ctl, C_DATA); end
        tick(1'b1);
        idle();
        id_is_branch = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd4; id_use_rs2 = 1'b1;
        mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd4; wb_regwrite = 1'b1; branch_taken_id = 1'b1;
        #1;
        total++; if ({fwd_br_a, fwd_br_b} !== 4'b1001) begin bad++; $display("FAIL branch_fwd got=%b exp=1001", {fwd_br_a, fwd_br_b}); end
        total++; if (ctl !== C_FLSH) begin bad++; $display("FAIL branch_flush got=%b exp=%b", ctl, C_FLSH); end
        tick(1'b0);
        idle();
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL branch_after_flush got=%b exp=%b", ctl, C_NONE); end
        tick(1'b0);
    endtask

    task automatic test_back_to_back_mul();
        logic [7:0] exp_ctl;
        base = exp_sc;
        idle();
        ex_multicycle = 1'b1;
        for (int op = 0; op < 2; op++) begin
            for (int c = 0; c < 3; c++) begin
                #1;
                exp_ctl = (c < 2) ? C_MUL : C_NONE;
                total++; if (ctl !== exp_ctl) begin bad++; $display("FAIL mul_ctl op=%0d c=%0d got=%b exp=%b", op, c, ctl, exp_ctl); end
                total++; if (mul_busy !== (c < 2)) begin bad++; $display("FAIL mul_busy op=%0d c=%0d got=%b exp=%b", op, c, mul_busy, (c < 2)); end
                tick(exp_ctl[7]);
            end
        end
        total++; if (stall_count !== base + 32'd4) begin bad++; $display("FAIL mul_stall_count got=%0d exp=%0d", stall_count, base + 32'd4); end
        idle();
        tick(1'b0);
    endtask

    task automatic test_memwait();
        idle();
        ex_multicycle = 1'b1;
        #1;
        total++; if (ctl !== C_MUL) begin bad++; $display("FAIL memwait_pre got=%b exp=%b", ctl, C_MUL); end
        tick(1'b1);
        base = exp_sc;
        mem_rd = 5'd9; mem_memread = 1'b1; mem_regwrite = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (ctl !== C_MEMW) begin bad++; $display("FAIL memwait_ctl c=%0d got=%b exp=%b", c, ctl, C_MEMW); end
            tick(1'b1);
        end
        mem_ready = 1'b1; mem_memread = 1'b0; mem_regwrite = 1'b0;
        #1;
        total++; if (ctl !== C_MUL) begin bad++; $display("FAIL memwait_mul_resume got=%b exp=%b", ctl, C_MUL); end
        tick(1'b1);
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL memwait_mul_release got=%b exp=%b", ctl, C_NONE); end
        total++; if (stall_count !== base + 32'd4) begin bad++; $display("FAIL memwait_count got=%0d exp=%0d", stall_count, base + 32'd4); end
        tick(1'b0);
        idle();
        tick(1'b0);
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] exp_ctl;
        idle();
        ex_multicycle = 1'b1;
        tick(1'b1);
        rst = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1; ex_rs1 = 5'd5;
        #1;
        total++; if ({ctl, mul_busy, fwd_a} !== 11'd0) begin bad++; $display("FAIL rst_mid_outputs got=%b exp=0", {ctl, mul_busy, fwd_a}); end
        tick(1'b0);
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", stall_count); end
        rst = 1'b0;
        #1;
        total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL rst_release_fwd got=%b exp=10", fwd_a); end
        for (int c = 0; c < 3; c++) begin
            exp_ctl = (c < 2) ? C_MUL : C_NONE;
            total++; if (ctl !== exp_ctl) begin bad++; $display("FAIL rst_restart c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
            tick(exp_ctl[7]);
        end
        total++; if (stall_count !== exp_sc) begin bad++; $display("FAIL rst_restart_count got=%0d exp=%0d", stall_count, exp_sc); end
        idle();
        tick(1'b0);
    endtask

    task automatic test_saturation();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        for (int c = 0; c < 9; c++) tick(1'b1);
        total++; if (s_stall_count !== exp_sc_s) begin bad++; $display("FAIL sat_small got=%0d exp=%0d", s_stall_count, exp_sc_s); end
        total++; if (s_stall_count !== 3'd7) begin bad++; $display("FAIL sat_small_max got=%0d exp=7", s_stall_count); end
        total++; if (stall_count !== exp_sc) begin bad++; $display("FAIL sat_wide got=%0d exp=%0d", stall_count, exp_sc); end
        idle();
        tick(1'b0);
    endtask

    initial begin
        exp_sc = '0;
        exp_sc_s = '0;
        base = '0;
        idle();
        #2;
        test_reset();
        test_ex_forwarding();
        test_load_use();
        test_branch();
        test_back_to_back_mul();
        test_memwait();
        test_reset_mid_mul();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
